// File: rtl/cp0_irq_timer.sv
// rtl/cp0_irq_timer.sv - CP0 subset: Status/Cause/EPC/BadVAddr, Count/Compare timer and interrupt request logic.
module cp0_irq_timer #(
   parameter int          HW_IRQ  = 6,
   parameter int          CNT_DIV = 2,
   parameter logic [31:0] PRID    = 32'h0000_4220
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_m,
   input  logic [31:0]       badaddr_in,
   input  logic [HW_IRQ-1:0] hw_int,
   input  logic              eret,
   input  logic              bd,
   input  logic              exc,
   input  logic [4:0]        exccode_in,
   input  logic [4:0]        addr,
   input  logic              wen,
   input  logic [31:0]       wd,
   output logic [31:0]       rd,
   output logic [31:0]       epc,
   output logic              int_req,
   output logic              timer_irq
);

   localparam logic [3:0] PRESC_LAST = 4'(CNT_DIV - 1);

   logic [31:0] badvaddr, count, compare, epc_q;
   logic [7:0]  im, ip;
   logic [4:0]  exccode;
   logic [3:0]  presc;
   logic        exl, ie, bd_q, ti, cnt_inc;
   logic [5:0]  hw_pad;
   logic        hw_pend, wen_eff, cnt_wr, cmp_wr;

   assign hw_pad    = 6'(hw_int);
   assign hw_pend   = ie & (|(ip & im));
   assign int_req   = !exl & (exc | hw_pend);
   assign wen_eff   = wen & !int_req & !eret;
   assign cnt_wr    = wen_eff & (addr == 5'd9);
   assign cmp_wr    = wen_eff & (addr == 5'd11);
   assign epc       = epc_q;
   assign timer_irq = ti;

   always_comb begin
      rd = 32'd0;
      case (addr)
         5'd8:    rd = badvaddr;
         5'd9:    rd = count;
         5'd11:   rd = compare;
         5'd12:   rd = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
         5'd13:   rd = {bd_q, ti, 14'd0, ip, 1'b0, exccode, 2'd0};
         5'd14:   rd = epc_q;
         5'd15:   rd = PRID;
         default: rd = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr <= 32'd0;
         count    <= 32'd0;
         compare  <= 32'd0;
         epc_q    <= 32'd0;
         im       <= 8'd0;
         ip       <= 8'd0;
         exccode  <= 5'd0;
         presc    <= 4'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd_q     <= 1'b0;
         ti       <= 1'b0;
         cnt_inc  <= 1'b0;
      end else begin
         ip[7:2] <= hw_pad | {ti, 5'd0};

         // cnt_inc marks that Count reached its current value by incrementing
         if (cnt_wr) begin
            count   <= wd;
            presc   <= 4'd0;
            cnt_inc <= 1'b0;
         end else if (presc == PRESC_LAST) begin
            presc   <= 4'd0;
            count   <= count + 32'd1;
            cnt_inc <= 1'b1;
         end else begin
            presc   <= presc + 4'd1;
            cnt_inc <= 1'b0;
         end

         if (cmp_wr)
            ti <= 1'b0;
         else if (cnt_inc && (count == compare) && !cnt_wr)
            ti <= 1'b1;

         if (int_req) begin
            exl   <= 1'b1;
            bd_q  <= bd;
            epc_q <= bd ? (pc_m - 32'd4) : pc_m;
            if (hw_pend) begin
               exccode <= 5'd0;
            end else begin
               exccode <= exccode_in;
               if (exccode_in == 5'd4 || exccode_in == 5'd5)
                  badvaddr <= badaddr_in;
            end
         end else if (eret) begin
            exl  <= 1'b0;
            bd_q <= 1'b0;
         end else if (wen) begin
            case (addr)
               5'd11: compare <= wd;
               5'd12: begin
                  im  <= wd[15:8];
                  exl <= wd[1];
                  ie  <= wd[0];
               end
               5'd13:   ip[1:0] <= wd[9:8];
               5'd14:   epc_q   <= wd;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/cp0_irq_timer.md
CP0_IRQ_TIMER -- requirements
Module: cp0_irq_timer

Interface
REQ-001 Parameter HW_IRQ, default 6, meaning number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_IRQ-1:2].
REQ-002 Parameter CNT_DIV, default 2, meaning clock cycles per Count increment (1..16).
REQ-003 Parameter PRID, default 32'h0000_4220, meaning the read-only value of the PRId register (reg 15).
REQ-004 Port clk  in  1  single clock; all state updates occur on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port pc_m  in  32  PC of the instruction in the M stage.
REQ-007 Port badaddr_in  in  32  faulting address from the M stage.
REQ-008 Port hw_int  in  HW_IRQ  level-sensitive hardware interrupt requests.
REQ-009 Port eret  in  1  ERET in the M stage.
REQ-010 Port bd  in  1  M-stage instruction sits in a delay slot.
REQ-011 Port exc  in  1  synchronous exception pending in the M stage.
REQ-012 Port exccode_in  in  5  code for exc.
REQ-013 Port addr  in  5  CP0 register number for read and write.
REQ-014 Port wen  in  1  MTC0 write enable.
REQ-015 Port wd  in  32  MTC0 write data.
REQ-016 Port rd  out  32  combinational read data for addr.
REQ-017 Port epc  out  32  registered EPC.
REQ-018 Port int_req  out  1  combinational flush/redirect request.
REQ-019 Port timer_irq  out  1  registered Cause.TI.

Function
REQ-020 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15); every other addr reads 32'd0 and ignores writes.
REQ-021 Status reads {9'd0, BEV=1, 6'd0, IM[7:0], 6'd0, EXL, IE}; the BEV bit is read-only.
REQ-022 Cause reads {BD, TI, 14'd0, IP[7:0], 1'b0, ExcCode[4:0], 2'd0}.
REQ-023 Every cycle, IP[7:2] latches {zero-pad, hw_int}, with IP[7] ORed with TI; IP[1:0] is software-written only (Cause write, wd[9:8]).
REQ-024 int_req = !EXL & (exc | (IE & |(IP & IM))), using registered IP.
REQ-025 Prescaler counts 0..CNT_DIV-1; Count increments by 1 when the prescaler wraps; Count wraps from 32'hFFFF_FFFF to 0 with no flag.
REQ-026 TI sets on the cycle after Count takes a value equal to Compare via increment; TI stays set until Compare is written.
REQ-027 Priority per cycle: int_req > eret > wen; Count and prescaler advance regardless, except on a Count write.
REQ-028 On int_req: EXL<=1, BD<=bd, EPC<=bd ? pc_m-4 : pc_m (mod 2^32).
REQ-029 On int_req, if IE & |(IP & IM): ExcCode<=0 and BadVAddr is held; otherwise ExcCode<=exccode_in, and BadVAddr<=badaddr_in only when exccode_in is 4 or 5.
REQ-030 On eret (no int_req): EXL<=0, BD<=0.
REQ-031 On wen (no int_req, no eret): Count<=wd and prescaler<=0; Compare<=wd and TI<=0; Status IM<=wd[15:8], EXL<=wd[1], IE<=wd[0]; Cause IP[1:0]<=wd[9:8]; EPC<=wd.
REQ-032 A Count write in the same cycle as a match suppresses TI set; a Compare write wins over a simultaneous TI set.
REQ-033 A Count write or Compare write that makes Count==Compare does not set TI; only an increment does.
REQ-034 rd and int_req are purely combinational from registered state and inputs; all other outputs are registered.

Reset
REQ-035 While reset=1 at a clock edge, all registers clear to 0 (BadVAddr, Count, Compare, IM, EXL, IE, BD, TI, IP, ExcCode, EPC, prescaler), overriding int_req, eret and wen.
REQ-036 After reset, rd for Status=32'h0040_0000, rd for PRId=PRID, and int_req=timer_irq=epc=0.

Verification
REQ-037 Timer: CNT_DIV=2, write Compare=5, Count=0 -> Count reaches 5 after 10 cycles, timer_irq=1 next cycle; Compare write clears it.
REQ-038 Interrupt: Status=32'h0000_8001, hold TI -> int_req=1, ExcCode=0, EXL=1, epc=pc_m; int_req drops next cycle.
REQ-039 Delay-slot exception: exc=1, exccode_in=4, bd=1, pc_m=32'h3004, badaddr_in=32'h13 -> epc=32'h3000, BD=1, BadVAddr=32'h13, Cause[6:2]=4.
REQ-040 Exception with exccode_in=10 -> BadVAddr unchanged; eret -> EXL=0, BD=0; same cycle wen ignored.
REQ-041 Wrap: Count=32'hFFFF_FFFF, Compare=0 -> Count=0, TI=1; Count write coinciding with the match -> TI stays 0.
REQ-042 Reset asserted mid-count with EXL=1 -> all state 0 next edge; HW_IRQ=2 build: hw_int=2'b10 -> IP=8'b0000_1000.
